pix_stream_proc: RTL and testbench
==================================

// Module: pix_stream_proc
// PURPOSE
//  Parametrised streaming pixel processor; successor to the fixed 320x320 per-pixel operator set.
//  Takes a raster-order pixel stream with valid/ready flow control and applies one runtime-selected
//  per-pixel operation: pass, inversion, grayscale or threshold.
//  Emits the processed pixel with x/y coordinates and frame markers for the write-back stage.
//  Frame geometry and channel layout are parameters. Each frame is armed by a command handshake.
// PARAMETERS
//  IMG_W   320  pixels per line (>=2)
//  IMG_H   320  lines per frame (>=2)
//  CW      8    bits per colour channel
//  NCH     3    channels per pixel; channel 0 = bits [CW-1:0]
//  XW      9    coordinate width; must satisfy 2**XW >= max(IMG_W,IMG_H)
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  cmd_valid   in   1       command offered
//  cmd_ready   out  1       command accepted when cmd_valid&cmd_ready
//  cmd_mode    in   2       0 PASS, 1 INVERT, 2 GRAY, 3 THRESH
//  cmd_arg     in   CW      threshold for THRESH; ignored in other modes
//  s_valid     in   1       input pixel valid
//  s_ready     out  1       input pixel accepted when s_valid&s_ready
//  s_data      in   NCH*CW  input pixel
//  m_valid     out  1       output pixel valid
//  m_ready     in   1       downstream accepts when m_valid&m_ready
//  m_data      out  NCH*CW  processed pixel
//  m_x, m_y    out  XW      coordinates of m_data
//  m_sof       out  1       m_x==0 && m_y==0
//  m_eof       out  1       m_x==IMG_W-1 && m_y==IMG_H-1
//  busy        out  1       high in RUN and DRAIN
//  frame_done  out  1       1-cycle pulse when the EOF pixel transfers on m_*
//  err         out  1       sticky: cmd_valid seen while busy
// BEHAVIOUR
//  Reset (async): state=IDLE; mode=0; arg=0; x=y=0; m_valid=0; m_data=0; m_x=m_y=0; err=0;
//   frame_done=0; cmd_ready=1 (combinational from state); s_ready=0.
//  States:
//   IDLE  -> RUN on cmd_valid. Latch mode and arg. Clear err. x=y=0.
//   RUN   -> DRAIN when the pixel with x==IMG_W-1, y==IMG_H-1 is accepted.
//   DRAIN -> IDLE when the EOF output transfers. frame_done=1 in that same cycle (registered pulse).
//  cmd_ready = (state==IDLE). cmd_valid outside IDLE: ignored, err<=1.
//  s_ready = (state==RUN) && (!m_valid || m_ready). One register stage: a single skid-free output register.
//  Latency: an input accepted at edge N appears on m_* after edge N (1 cycle).
//   Full throughput of 1 pixel/clk while m_ready=1.
//  m_valid is held with m_data/m_x/m_y stable until m_ready. If m_ready is low, m_* never changes.
//  Counters advance only on input acceptance. x wraps at IMG_W-1 to 0 and then y increments.
//   y wraps to 0 after the last line.
//  Arithmetic (per channel c, MAX=2**CW-1):
//   PASS   out=c
//   INVERT out=MAX-c
//   GRAY   g=floor(sum(c)/NCH). Sum width is CW+$clog2(NCH+1), so there is no overflow.
//          g is replicated to all channels.
//   THRESH g as for GRAY; all channels = (g>=arg) ? MAX : 0
//  Mode and arg are frozen from command acceptance until return to IDLE.
//  Reset mid-frame aborts immediately. No frame_done is produced. The stream restarts at x=y=0
//   after the next command.
// TESTING
//  Use IMG_W=4, IMG_H=2, CW=8, NCH=3 unless noted.
//  T1 INVERT: send cmd mode=1, then 8 pixels 0x102030 with m_ready=1.
//     -> 8 outputs 0xEFDFCF. Coordinates (0,0)..(3,1). m_sof on the first output, m_eof on the last.
//     frame_done pulses once. busy drops the next cycle.
//  T2 GRAY/THRESH: pixel 0x0A141E in GRAY -> 0x141414.
//     THRESH arg=0x15 -> 0x000000. THRESH arg=0x14 -> 0xFFFFFF. Max pixel 0xFFFFFF in GRAY -> 0xFFFFFF.
//  T3 Backpressure: hold m_ready=0 for 5 cycles mid-frame.
//     -> s_ready=0, m_* stable, no pixel lost or duplicated. Order and coordinates stay intact.
//  T4 Command while busy: cmd_valid in RUN -> cmd_ready=0, err=1, mode unchanged.
//     err stays set until the next accepted cmd, which clears it.
//  T5 Reset mid-frame: assert rst_n=0 after 3 pixels.
//     -> m_valid=0, busy=0, no frame_done. A new cmd restarts at (0,0).
//  T6 Wrap: IMG_W=320, IMG_H=320 PASS frame, random s_valid/m_ready.
//     -> exactly 102400 outputs. The last output is (319,319) with m_eof=1. Data equals input.

Source files
------------

// File: rtl/pix_stream_proc.sv
// pix_stream_proc: raster-order streaming pixel processor.
// A command arms one frame and selects the operation (pass, invert, gray, threshold).
// Pixels flow through a single output register that carries coordinates and frame markers.
module pix_stream_proc #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 320,
    parameter int CW    = 8,
    parameter int NCH   = 3,
    parameter int XW    = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [CW-1:0]       cmd_arg,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [NCH*CW-1:0]   s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [NCH*CW-1:0]   m_data,
    output logic [XW-1:0]       m_x,
    output logic [XW-1:0]       m_y,
    output logic                m_sof,
    output logic                m_eof,
    output logic                busy,
    output logic                frame_done,
    output logic                err
);

    localparam int DW = NCH * CW;
    localparam int SW = CW + $clog2(NCH + 1);

    localparam logic [1:0] MODE_PASS   = 2'd0;
    localparam logic [1:0] MODE_INVERT = 2'd1;
    localparam logic [1:0] MODE_GRAY   = 2'd2;
    localparam logic [1:0] MODE_THRESH = 2'd3;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [XW-1:0] Y_LAST = XW'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [1:0]          mode_r;
    logic [CW-1:0]       arg_r;
    logic [XW-1:0]       x_r;
    logic [XW-1:0]       y_r;
    logic                m_valid_r;
    logic [DW-1:0]       m_data_r;
    logic [XW-1:0]       m_x_r;
    logic [XW-1:0]       m_y_r;
    logic                m_sof_r;
    logic                m_eof_r;
    logic                frame_done_r;
    logic                err_r;
    logic                in_fire_s;
    logic                out_fire_s;
    logic                last_in_s;
    logic [DW-1:0]       proc_s;

    // Per-pixel operator. Inversion per channel (MAX-c) is a plain bitwise NOT.
    // Gray is the floor of the channel mean; the sum is wide enough never to overflow.
    function automatic logic [DW-1:0] apply_op(input logic [1:0]    mode,
                                               input logic [CW-1:0] arg,
                                               input logic [DW-1:0] pix);
        logic [SW-1:0] sum;
        logic [CW-1:0] g;
        logic [DW-1:0] res;
        sum = '0;
        for (int c = 0; c < NCH; c++) begin
            sum = sum + SW'(pix[c*CW +: CW]);
        end
        g   = CW'(sum / SW'(NCH));
        res = '0;
        case (mode)
            MODE_PASS:   res = pix;
            MODE_INVERT: res = ~pix;
            MODE_GRAY:   res = {NCH{g}};
            MODE_THRESH: res = (g >= arg) ? {DW{1'b1}} : {DW{1'b0}};
            default:     res = pix;
        endcase
        return res;
    endfunction

    assign in_fire_s  = s_valid && s_ready;
    assign out_fire_s = m_valid_r && m_ready;
    assign last_in_s  = (x_r == X_LAST) && (y_r == Y_LAST);
    assign proc_s     = apply_op(mode_r, arg_r, s_data);

    assign m_valid    = m_valid_r;
    assign m_data     = m_data_r;
    assign m_x        = m_x_r;
    assign m_y        = m_y_r;
    assign m_sof      = m_sof_r;
    assign m_eof      = m_eof_r;
    assign frame_done = frame_done_r;
    assign err        = err_r;

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame sequencing: arm on command, drain after the last pixel enters, idle once it leaves.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) state_nxt_s = ST_RUN;
                else           state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (in_fire_s && last_in_s) state_nxt_s = ST_DRAIN;
                else                        state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (out_fire_s) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake and status decode; input is taken only when the output register can make room.
    always_comb begin
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        busy      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_RUN: begin
                s_ready = !m_valid_r || m_ready;
                busy    = 1'b1;
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Command latch and raster counters; counters move only on accepted input pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= 2'd0;
            arg_r  <= '0;
            x_r    <= '0;
            y_r    <= '0;
        end else if ((state_r == ST_IDLE) && cmd_valid) begin
            mode_r <= cmd_mode;
            arg_r  <= cmd_arg;
            x_r    <= '0;
            y_r    <= '0;
        end else if (in_fire_s) begin
            if (x_r == X_LAST) begin
                x_r <= '0;
                y_r <= (y_r == Y_LAST) ? '0 : (y_r + XW'(1));
            end else begin
                x_r <= x_r + XW'(1);
            end
        end
    end

    // Sticky protocol error: set by a command offered while busy, cleared by an accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (cmd_valid) begin
            err_r <= (state_r != ST_IDLE);
        end else begin
            err_r <= err_r;
        end
    end

    // Single output stage; contents are frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_x_r     <= '0;
            m_y_r     <= '0;
            m_sof_r   <= 1'b1;
            m_eof_r   <= 1'b0;
        end else if (in_fire_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= proc_s;
            m_x_r     <= x_r;
            m_y_r     <= y_r;
            m_sof_r   <= (x_r == '0) && (y_r == '0);
            m_eof_r   <= last_in_s;
        end else if (out_fire_s) begin
            m_valid_r <= 1'b0;
        end
    end

    // One-cycle completion pulse following the transfer of the end-of-frame pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= (state_r == ST_DRAIN) && out_fire_s;
        end
    end

endmodule

// File: tb/tb_pix_stream_proc.sv
// Bench for pix_stream_proc: constant-pixel vector table, hand sequences for
// backpressure / busy command / mid-frame reset, random frames and a wide-line wrap frame.
module tb_pix_stream_proc;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int WW = 320;
    localparam int WH = 4;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_mode;
    logic [7:0]  cmd_arg;
    logic        s_valid, s_ready;
    logic [23:0] s_data;
    logic        m_valid, m_ready;
    logic [23:0] m_data;
    logic [8:0]  m_x, m_y;
    logic        m_sof, m_eof, busy, frame_done, err;

    logic        w_cmd_valid, w_cmd_ready;
    logic [1:0]  w_cmd_mode;
    logic [7:0]  w_cmd_arg;
    logic        w_s_valid, w_s_ready;
    logic [23:0] w_s_data;
    logic        w_m_valid, w_m_ready;
    logic [23:0] w_m_data;
    logic [8:0]  w_m_x, w_m_y;
    logic        w_m_sof, w_m_eof, w_busy, w_frame_done, w_err;

    int checks = 0;
    int errors = 0;

    pix_stream_proc #(.IMG_W(W), .IMG_H(H), .CW(8), .NCH(3), .XW(9)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_arg(cmd_arg),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_x(m_x), .m_y(m_y),
        .m_sof(m_sof), .m_eof(m_eof), .busy(busy), .frame_done(frame_done), .err(err)
    );

    pix_stream_proc #(.IMG_W(WW), .IMG_H(WH), .CW(8), .NCH(3), .XW(9)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready), .cmd_mode(w_cmd_mode), .cmd_arg(w_cmd_arg),
        .s_valid(w_s_valid), .s_ready(w_s_ready), .s_data(w_s_data),
        .m_valid(w_m_valid), .m_ready(w_m_ready), .m_data(w_m_data), .m_x(w_m_x), .m_y(w_m_y),
        .m_sof(w_m_sof), .m_eof(w_m_eof), .busy(w_busy), .frame_done(w_frame_done), .err(w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference operator from the channel arithmetic rules.
    function automatic logic [23:0] model_op(input int mode, input int arg, input logic [23:0] p);
        int ch[3];
        int g;
        logic [23:0] r;
        for (int i = 0; i < 3; i++) ch[i] = int'((p >> (8 * i)) & 24'hFF);
        g = (ch[0] + ch[1] + ch[2]) / 3;
        case (mode)
            0:       r = p;
            1:       r = 24'((255 - ch[2]) * 65536 + (255 - ch[1]) * 256 + (255 - ch[0]));
            2:       r = 24'(g * 65793);
            3:       r = (g >= arg) ? 24'hFFFFFF : 24'h000000;
            default: r = p;
        endcase
        return r;
    endfunction

    // Scoreboard for the small-frame instance.
    typedef struct {
        logic [23:0] d;
        int          x;
        int          y;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          k = 0;
    int          cur_mode = 0;
    int          cur_arg = 0;
    bit          fd_exp = 1'b0;
    int          fd_cnt = 0;
    bit          hold_v = 1'b0;
    logic [23:0] hold_d;
    logic [8:0]  hold_x, hold_y;
    logic [23:0] last_out;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            k = 0;
            fd_exp = 1'b0;
            hold_v = 1'b0;
        end else begin
            chk("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
            if (frame_done) fd_cnt++;
            fd_exp = 1'b0;
            if (hold_v) begin
                chk("hold_valid", {31'd0, m_valid}, 32'd1);
                chk("hold_data", {8'd0, m_data}, {8'd0, hold_d});
                chk("hold_xy", {14'd0, m_x, m_y}, {14'd0, hold_x, hold_y});
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            hold_x = m_x;
            hold_y = m_y;
            if (cmd_valid && cmd_ready) begin
                k = 0;
                cur_mode = int'(cmd_mode);
                cur_arg = int'(cmd_arg);
            end
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_output", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    last_out = m_data;
                    chk("out_data", {8'd0, m_data}, {8'd0, e.d});
                    chk("out_x", {23'd0, m_x}, 32'(e.x));
                    chk("out_y", {23'd0, m_y}, 32'(e.y));
                    chk("out_sof", {31'd0, m_sof}, 32'((e.x == 0) && (e.y == 0)));
                    chk("out_eof", {31'd0, m_eof}, 32'((e.x == W - 1) && (e.y == H - 1)));
                    fd_exp = (e.x == W - 1) && (e.y == H - 1);
                end
            end
            if (s_valid && s_ready) begin
                e.d = model_op(cur_mode, cur_arg, s_data);
                e.x = k % W;
                e.y = (k / W) % H;
                q.push_back(e);
                k = (k + 1) % (W * H);
            end
        end
    end

    // Scoreboard for the wide-line instance (PASS: output equals input, in order).
    logic [23:0] wq[$];
    logic [23:0] wd;
    int          wk = 0;
    int          w_last_x = 0;
    int          w_last_y = 0;
    int          w_last_eof = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            wq.delete();
            wk = 0;
        end else begin
            if (w_cmd_valid && w_cmd_ready) wk = 0;
            if (w_m_valid && w_m_ready) begin
                if (wq.size() == 0) begin
                    chk("wrap_spurious", 32'd1, 32'd0);
                end else begin
                    wd = wq.pop_front();
                    chk("wrap_data", {8'd0, w_m_data}, {8'd0, wd});
                    chk("wrap_x", {23'd0, w_m_x}, 32'(wk % WW));
                    chk("wrap_y", {23'd0, w_m_y}, 32'((wk / WW) % WH));
                    chk("wrap_eof", {31'd0, w_m_eof}, 32'(wk == WW * WH - 1));
                end
                w_last_x = int'(w_m_x);
                w_last_y = int'(w_m_y);
                w_last_eof = int'(w_m_eof);
                wk++;
            end
            if (w_s_valid && w_s_ready) wq.push_back(w_s_data);
        end
    end

    int last_cycles = 0;

    task automatic send_cmd(input int mode, input int arg);
        int b;
        b = 0;
        while (!cmd_ready && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_mode = 2'(mode);
        cmd_arg = 8'(arg);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("busy_after_cmd", {31'd0, busy}, 32'd1);
    endtask

    task automatic stream(input int n, input bit rnd, input logic [23:0] pix, input int vp, input int rp);
        int cnt;
        int b;
        cnt = 0;
        b = 0;
        while (cnt < n && b < 5000) begin
            s_valid = ($urandom_range(0, 99) < vp);
            m_ready = ($urandom_range(0, 99) < rp);
            s_data = rnd ? 24'($urandom) : pix;
            @(negedge clk);
            if (s_valid && s_ready) cnt++;
            @(posedge clk); #1;
            b++;
        end
        s_valid = 1'b0;
        last_cycles = b;
        if (cnt < n) chk("stream_timeout", 32'(cnt), 32'(n));
    endtask

    task automatic drain();
        int b;
        b = 0;
        m_ready = 1'b1;
        while (busy && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        chk("busy_drop", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  arg;
        logic [23:0] pix;
        logic [23:0] exp;
    } vec_t;

    vec_t vt[10];

    initial begin
        int fd0;
        int cnt;
        int b;

        vt[0] = '{2'd1, 8'h00, 24'h102030, 24'hEFDFCF};
        vt[1] = '{2'd2, 8'h00, 24'h0A141E, 24'h141414};
        vt[2] = '{2'd3, 8'h15, 24'h0A141E, 24'h000000};
        vt[3] = '{2'd3, 8'h14, 24'h0A141E, 24'hFFFFFF};
        vt[4] = '{2'd2, 8'h00, 24'hFFFFFF, 24'hFFFFFF};
        vt[5] = '{2'd0, 8'hAA, 24'h123456, 24'h123456};
        vt[6] = '{2'd2, 8'h00, 24'h000102, 24'h010101};
        vt[7] = '{2'd2, 8'h00, 24'h000001, 24'h000000};
        vt[8] = '{2'd3, 8'h00, 24'h000000, 24'hFFFFFF};
        vt[9] = '{2'd1, 8'h00, 24'hFF0000, 24'h00FFFF};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_arg = 8'd0;
        s_valid = 1'b0; s_data = 24'd0; m_ready = 1'b0;
        w_cmd_valid = 1'b0; w_cmd_mode = 2'd0; w_cmd_arg = 8'd0;
        w_s_valid = 1'b0; w_s_data = 24'd0; w_m_ready = 1'b0;

        #3;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_busy_err_fd", {29'd0, busy, err, frame_done}, 32'd0);
        chk("rst_m_data", {8'd0, m_data}, 32'd0);
        chk("rst_m_xy", {14'd0, m_x, m_y}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Constant-pixel frames, one per table entry, at full throughput.
        for (int i = 0; i < 10; i++) begin
            fd0 = fd_cnt;
            send_cmd(int'(vt[i].mode), int'(vt[i].arg));
            stream(W * H, 1'b0, vt[i].pix, 100, 100);
            chk("throughput", 32'(last_cycles), 32'(W * H));
            drain();
            chk("vec_result", {8'd0, last_out}, {8'd0, vt[i].exp});
            chk("frame_done_once", 32'(fd_cnt - fd0), 32'd1);
        end

        // Backpressure mid-frame.
        send_cmd(0, 0);
        stream(3, 1'b1, 24'd0, 100, 100);
        s_valid = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_data = 24'($urandom);
            @(negedge clk);
            chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
            chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        stream(W * H - 3, 1'b1, 24'd0, 100, 100);
        drain();

        // Command while busy.
        send_cmd(1, 0);
        stream(4, 1'b1, 24'd0, 100, 100);
        cmd_valid = 1'b1;
        cmd_mode = 2'd2;
        @(negedge clk);
        chk("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("err_set", {31'd0, err}, 32'd1);
        stream(4, 1'b1, 24'd0, 100, 100);
        drain();
        chk("err_sticky", {31'd0, err}, 32'd1);
        send_cmd(0, 0);
        chk("err_cleared", {31'd0, err}, 32'd0);
        stream(W * H, 1'b1, 24'd0, 100, 100);
        drain();

        // Reset mid-frame.
        send_cmd(2, 0);
        stream(3, 1'b1, 24'd0, 100, 100);
        fd0 = fd_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_m_valid", {31'd0, m_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("abort_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
        send_cmd(3, 8'h80);
        stream(W * H, 1'b1, 24'd0, 100, 100);
        drain();

        // Random frames with random flow control.
        for (int f = 0; f < 8; f++) begin
            fd0 = fd_cnt;
            send_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            stream(W * H, 1'b1, 24'd0, 70, 60);
            drain();
            chk("rand_frame_done", 32'(fd_cnt - fd0), 32'd1);
        end

        // Wide-line PASS frame with random valid/ready.
        chk("wrap_cmd_ready", {31'd0, w_cmd_ready}, 32'd1);
        w_cmd_valid = 1'b1;
        w_cmd_mode = 2'd0;
        @(posedge clk); #1;
        w_cmd_valid = 1'b0;
        cnt = 0;
        b = 0;
        while (cnt < WW * WH && b < 30000) begin
            w_s_valid = ($urandom_range(0, 99) < 75);
            w_m_ready = ($urandom_range(0, 99) < 65);
            w_s_data = 24'($urandom);
            @(negedge clk);
            if (w_s_valid && w_s_ready) cnt++;
            @(posedge clk); #1;
            b++;
        end
        w_s_valid = 1'b0;
        w_m_ready = 1'b1;
        chk("wrap_inputs", 32'(cnt), 32'(WW * WH));
        b = 0;
        while (w_busy && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        @(posedge clk); #1;
        chk("wrap_busy_drop", {31'd0, w_busy}, 32'd0);
        chk("wrap_count", 32'(wk), 32'(WW * WH));
        chk("wrap_last_xy", 32'(w_last_x * 1000 + w_last_y), 32'((WW - 1) * 1000 + (WH - 1)));
        chk("wrap_last_eof", 32'(w_last_eof), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
